ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one buffer RAM (write port plus registered read port, write-priority) between two requesters: a loader (writes) and a systolic-array feeder (reads).
- Grants at most one access per cycle. Both requesters use valid/ready handshakes.
- When both requesters are active, the block alternates ownership in bursts of up to BURST grants, so neither side starves.
- Sits between the tile loader / PE-row feeder and the RAM instance, driving the RAM's control pins directly.

Parameters:
- DW, 8, data width (matches RAM DW).
- ADDR_DW, 4, address width (matches RAM ADDR_DW).
- BURST, 4, maximum consecutive grants to one requester while the other is waiting; legal range is 1 or more.
- CNT_W, derived as clog2(BURST+1), width of the burst counter; local, not overridable.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- wr_valid, in, 1, loader requests a write.
- wr_addr, in, ADDR_DW, write address.
- wr_data, in, DW, write data.
- wr_ready, out, 1, write granted this cycle.
- rd_valid, in, 1, feeder requests a read.
- rd_addr, in, ADDR_DW, read address.
- rd_ready, out, 1, read granted this cycle.
- rd_rvalid, out, 1, read data valid (one cycle after the read grant).
- rd_rdata, out, DW, read data (passthrough of ram_dout).
- ram_we, out, 1, drives RAM WRenable.
- ram_re, out, 1, drives RAM RAenable.
- ram_addr_w, out, ADDR_DW, drives RAM addr_w (equal to wr_addr).
- ram_addr_r, out, ADDR_DW, drives RAM addr_r (equal to rd_addr).
- ram_din, out, DW, drives RAM din (equal to wr_data).
- ram_dout, in, DW, RAM dout.

Behaviour:
- State registers: cur (owner of the last grant, W or R) and cnt (consecutive grants to cur, saturating at BURST).
- Reset (asynchronous, immediate): cur=W, cnt=0, rd_rvalid=0. All other outputs are combinational.
- Grant decision (combinational, same cycle as the request):
  - Only wr_valid high: grant W.
  - Only rd_valid high: grant R.
  - Both high: grant cur if cnt < BURST, otherwise grant the other requester.
  - Neither high: no grant.
- Grant outputs:
  - wr_ready = grant W; rd_ready = grant R.
  - ram_we = grant W; ram_re = grant R.
  - ram_we and ram_re are never high together.
  - A transfer occurs when valid and ready are both high.
- State update:
  - Grant to cur: cnt <= min(cnt+1, BURST).
  - Grant to the other requester: cur <= granted requester, cnt <= 1.
  - No grant: cnt <= 0, cur unchanged.
- Read latency:
  - rd_rvalid <= grant R, registered, so it is high exactly one cycle after the rd_valid and rd_ready handshake.
  - rd_rdata = ram_dout. It holds its value when no read was granted; consumers sample it only when rd_rvalid is high.
- Hazards:
  - A write and a read to the same address in consecutive cycles is safe: the read returns the value held before or after the write according to grant order.
  - No forwarding is performed.
- wr_ready and rd_ready may depend combinationally on wr_valid and rd_valid. Requesters must not make valid depend on ready.
- Reset during an outstanding read (grant in cycle k, rst before edge k+1): rd_rvalid stays 0 and the read is dropped.
- BURST=1: strict alternation while both requesters are valid.

Decomposition:
- Shared package holds:
  - Owner encoding constants OWN_W=1'b0 and OWN_R=1'b1.
  - Default DW and ADDR_DW values, shared with ram_new.
- No sub-module is needed. The grant logic is a single always_comb block; the test bench instantiates ram_new alongside this block.

Test Plan:
- Writes only: wr_valid high for 6 cycles, addr 0..5, data 0x10..0x15 -> wr_ready and ram_we high all 6 cycles, rd_ready 0, RAM holds 0x10..0x15.
- Read after load: rd_valid high for 1 cycle with addr 3 -> rd_ready high that cycle, rd_rvalid high the next cycle with rd_rdata=0x13, then rd_rvalid low.
- Contention with BURST=4 after reset, both valid continuously for 12 cycles -> grants W W W W R R R R W W W W, and ram_we and ram_re are never high together.
- Burst break: 2 W grants, then 1 idle cycle (no valids), then both valid -> cnt resets to 0, W gets 4 more grants before R.
- Reset mid-read: read granted at cycle k, rst pulsed between edges k and k+1 -> rd_rvalid stays 0, cur=W, cnt=0; the next contention starts with W.
- BURST=1 elaboration with both requesters valid for 6 cycles -> grants W R W R W R; each R is followed by rd_rvalid the next cycle.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: owner encodings and default widths shared by the arbiter, its interface and ram_new
package ram_port_arbiter_pkg;
  localparam logic OWN_W = 1'b0;
  localparam logic OWN_R = 1'b1;
  localparam int DEF_DW = 8;
  localparam int DEF_ADDR_DW = 4;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes plus RAM control pins; slave = arbiter side, master = requesters/RAM side
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int ADDR_DW = DEF_ADDR_DW
);
  logic wr_valid;
  logic [ADDR_DW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic wr_ready;
  logic rd_valid;
  logic [ADDR_DW-1:0] rd_addr;
  logic rd_ready;
  logic rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic ram_we;
  logic ram_re;
  logic [ADDR_DW-1:0] ram_addr_w;
  logic [ADDR_DW-1:0] ram_addr_r;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  modport slave (
    input wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout,
    output wr_ready, rd_ready, rd_rvalid, rd_rdata, ram_we, ram_re, ram_addr_w, ram_addr_r, ram_din
  );
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout,
    input wr_ready, rd_ready, rd_rvalid, rd_rdata, ram_we, ram_re, ram_addr_w, ram_addr_r, ram_din
  );
endinterface

// File: rtl/ram_new.sv
// ram_new: buffer RAM with a write port and a registered, write-priority read port; dout holds when not read
module ram_new
  import ram_port_arbiter_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int ADDR_DW = DEF_ADDR_DW
) (
  input  logic clk,
  input  logic we,
  input  logic re,
  input  logic [ADDR_DW-1:0] addr_w,
  input  logic [ADDR_DW-1:0] addr_r,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] r_mem [2**ADDR_DW];
  always_ff @(posedge clk) begin
    if (we) r_mem[addr_w] <= din;
    if (re) dout <= (we && addr_w == addr_r) ? din : r_mem[addr_r];
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: one-access-per-cycle RAM sharing between loader writes and feeder reads,
// alternating in bursts of up to BURST grants under contention
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst,
  ram_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(BURST + 1);
  logic r_cur;
  logic [CNT_W-1:0] r_cnt;
  logic w_keep, w_gw, w_gr;
  always_comb begin
    w_keep = r_cnt < CNT_W'(BURST);
    // under contention stay with the current owner until its burst is spent
    w_gw = bus.wr_valid & (~bus.rd_valid | ((r_cur == OWN_W) ? w_keep : ~w_keep));
    w_gr = bus.rd_valid & ~w_gw;
  end
  assign bus.wr_ready = w_gw;
  assign bus.rd_ready = w_gr;
  assign bus.ram_we = w_gw;
  assign bus.ram_re = w_gr;
  assign bus.ram_addr_w = bus.wr_addr;
  assign bus.ram_addr_r = bus.rd_addr;
  assign bus.ram_din = bus.wr_data;
  assign bus.rd_rdata = bus.ram_dout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= OWN_W;
      r_cnt <= '0;
      bus.rd_rvalid <= 1'b0;
    end else begin
      bus.rd_rvalid <= w_gr;
      if (!w_gw && !w_gr) r_cnt <= '0;
      else if (w_gr == r_cur) r_cnt <= w_keep ? r_cnt + CNT_W'(1) : r_cnt;
      else begin
        r_cur <= w_gr;
        r_cnt <= CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of grants, burst alternation, read latency and reset behaviour
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_tot = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ram_port_arbiter_if bus();
  ram_port_arbiter_if bus1();
  ram_port_arbiter #(.BURST(4)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  ram_new u_ram (
    .clk(clk), .we(bus.ram_we), .re(bus.ram_re), .addr_w(bus.ram_addr_w),
    .addr_r(bus.ram_addr_r), .din(bus.ram_din), .dout(bus.ram_dout)
  );
  ram_port_arbiter #(.BURST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  assign bus1.ram_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [3:0] ra);
    @(negedge clk);
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_valid = rv; bus.rd_addr = ra;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic contend(input string tag, input int n, input logic [11:0] pat);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 4'hF, 8'hAA, 1'b1, 4'h1);
      chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(!pat[i]));
      chk({tag, "_rd_ready"}, 32'(bus.rd_ready), 32'(pat[i]));
      chk({tag, "_excl"}, 32'(bus.ram_we & bus.ram_re), 32'd0);
      tick();
      chk({tag, "_rvalid"}, 32'(bus.rd_rvalid), 32'(pat[i]));
      if (pat[i]) chk({tag, "_rdata"}, 32'(bus.rd_rdata), 32'h11);
    end
    drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
    tick();
  endtask

  initial begin
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.rd_valid = 0; bus.rd_addr = 0;
    bus1.wr_valid = 0; bus1.wr_addr = 0; bus1.wr_data = 0; bus1.rd_valid = 0; bus1.rd_addr = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rvalid", 32'(bus.rd_rvalid), 32'd0);
    chk("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("reset_rd_ready", 32'(bus.rd_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 4'h0);
      chk("wr_only_ready", 32'(bus.wr_ready), 32'd1);
      chk("wr_only_we", 32'(bus.ram_we), 32'd1);
      chk("wr_only_rd_ready", 32'(bus.rd_ready), 32'd0);
      chk("wr_only_addr", 32'(bus.ram_addr_w), 32'(i));
      chk("wr_only_din", 32'(bus.ram_din), 32'(8'h10 + i));
      tick();
    end
    drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
    chk("rd_ready", 32'(bus.rd_ready), 32'd1);
    chk("rd_re", 32'(bus.ram_re), 32'd1);
    chk("rd_early_rvalid", 32'(bus.rd_rvalid), 32'd0);
    tick();
    chk("rd_rvalid", 32'(bus.rd_rvalid), 32'd1);
    chk("rd_rdata", 32'(bus.rd_rdata), 32'h13);
    drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
    tick();
    chk("rd_rvalid_drop", 32'(bus.rd_rvalid), 32'd0);
    chk("rd_rdata_hold", 32'(bus.rd_rdata), 32'h13);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    contend("burst4", 12, 12'b0000_1111_0000);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'hE, 8'h55, 1'b0, 4'h0);
      chk("brk_wr_ready", 32'(bus.wr_ready), 32'd1);
      tick();
    end
    drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
    tick();
    contend("brk", 5, 12'b0000_0001_0000);
    drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h2);
    chk("mid_rd_ready", 32'(bus.rd_ready), 32'd1);
    #1;
    rst = 1'b1;
    bus.rd_valid = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.rd_rvalid), 32'd0);
    tick();
    chk("mid_rst_rvalid_edge", 32'(bus.rd_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    contend("post_rst", 5, 12'b0000_0001_0000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus1.wr_valid = 1'b1; bus1.rd_valid = 1'b1; bus1.wr_addr = 4'(i); bus1.rd_addr = 4'(i);
      #1;
      chk("b1_wr_ready", 32'(bus1.wr_ready), 32'(i % 2 == 0));
      chk("b1_rd_ready", 32'(bus1.rd_ready), 32'(i % 2 == 1));
      tick();
      chk("b1_rvalid", 32'(bus1.rd_rvalid), 32'(i % 2 == 1));
    end
    @(negedge clk);
    bus1.wr_valid = 1'b0; bus1.rd_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
